// File: rtl/mat_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier: sizing helpers
// and the controller state encoding.
package mat_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Default result width: a full DW x DW product plus headroom for N terms.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mat_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b, with both operands
// widened to the accumulator width (sign- or zero-extended).
module mat_mac #(
    parameter int DW     = 8,
    parameter int ACC_W  = 17,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] sum_o
);

    logic             a_sx;
    logic             b_sx;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    assign a_sx  = SIGNED ? a_i[DW-1] : 1'b0;
    assign b_sx  = SIGNED ? b_i[DW-1] : 1'b0;
    assign a_ext = {{(ACC_W-DW){a_sx}}, a_i};
    assign b_ext = {{(ACC_W-DW){b_sx}}, b_i};

    // The low ACC_W bits of the widened product are exact in two's complement.
    assign prod  = a_ext * b_ext;
    assign sum_o = acc_i + prod;

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiplier: latches A and B, then walks i/j/k through
// one shared MAC, one product term per clock, and holds Res until consumed.
module mat_mult_seq
    import mat_pkg::*;
#(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = acc_width(N, DW)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*N*DW-1:0]    A,
    input  logic [N*N*DW-1:0]    B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*ACC_W-1:0] Res
);

    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e                 state_q;
    logic [N*N*DW-1:0]      a_q;
    logic [N*N*DW-1:0]      b_q;
    logic [N*N*ACC_W-1:0]   res_q;
    logic [ACC_W-1:0]       acc_q;
    logic [CW-1:0]          i_q;
    logic [CW-1:0]          j_q;
    logic [CW-1:0]          k_q;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic [DW-1:0]          a_el_d;
    logic [DW-1:0]          b_el_d;
    logic [ACC_W-1:0]       sum_d;
    int                     a_idx;
    int                     b_idx;
    int                     res_idx;

    // Element [r][c] of a row-major bus sits at slot N*N-1-(r*N+c) from the LSB.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        a_idx   = N * N - 1 - (int'(i_q) * N + int'(k_q));
        b_idx   = N * N - 1 - (int'(k_q) * N + int'(j_q));
        res_idx = N * N - 1 - (int'(i_q) * N + int'(j_q));
        a_el_d  = a_q[a_idx*DW +: DW];
        b_el_d  = b_q[b_idx*DW +: DW];
    end

    mat_mac #(
        .DW     (DW),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a_i   (a_el_d),
        .b_i   (b_el_d),
        .acc_i (acc_q),
        .sum_o (sum_d)
    );

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            // NOTE: the result store is reset too, because Res must read zero after an aborted job.
            res_q       <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        i_q        <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (k_q != LAST) begin
                        acc_q <= sum_d;
                        k_q   <= k_q + CW'(1);
                    end else begin
                        res_q[res_idx*ACC_W +: ACC_W] <= sum_d;
                        acc_q <= '0;
                        k_q   <= '0;
                        if (j_q != LAST) begin
                            j_q <= j_q + CW'(1);
                        end else begin
                            j_q <= '0;
                            if (i_q != LAST) begin
                                i_q <= i_q + CW'(1);
                            end else begin
                                i_q         <= '0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Res       = res_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: N=2 unsigned and signed 8-bit instances and
// an N=3 4-bit unsigned instance, checked against hand-computed products.
module tb_mat_mult_seq;

    logic        clk;
    logic        rst_n;

    logic [31:0] a_2;
    logic [31:0] b_2;

    logic        in_valid_u, in_ready_u, out_valid_u, out_ready_u;
    logic [67:0] res_u;
    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [67:0] res_s;

    logic        in_valid_3, in_ready_3, out_valid_3, out_ready_3;
    logic [35:0] a_3;
    logic [35:0] b_3;
    logic [89:0] res_3;

    int n_tests;
    int n_fail;

    mat_mult_seq #(.N(2), .DW(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid_u), .in_ready(in_ready_u),
        .A(a_2), .B(b_2),
        .out_valid(out_valid_u), .out_ready(out_ready_u),
        .Res(res_u)
    );

    mat_mult_seq #(.N(2), .DW(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .A(a_2), .B(b_2),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .Res(res_s)
    );

    mat_mult_seq #(.N(3), .DW(4), .SIGNED(1'b0)) dut_3 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid_3), .in_ready(in_ready_3),
        .A(a_3), .B(b_3),
        .out_valid(out_valid_3), .out_ready(out_ready_3),
        .Res(res_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_res2(input bit sel, input string tag, input longint exp [4]);
        logic [16:0] elem;
        longint      got;
        for (int e = 0; e < 4; e++) begin
            elem = sel ? res_s[(3-e)*17 +: 17] : res_u[(3-e)*17 +: 17];
            got  = sel ? longint'($signed(elem)) : longint'(elem);
            check($sformatf("%s_res%0d", tag, e), got, exp[e]);
        end
    endtask

    // Runs one job on an N=2 instance; hold = cycles of out_ready=0 in DONE.
    task automatic run2(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input longint exp [4], input string tag, input int hold);
        int lat;
        @(negedge clk);
        a_2 = a;
        b_2 = b;
        check({tag, "_rdy_idle"}, longint'(sel ? in_ready_s : in_ready_u), 1);
        if (sel) in_valid_s = 1'b1; else in_valid_u = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s = 1'b0;
        in_valid_u = 1'b0;
        check({tag, "_rdy_calc"}, longint'(sel ? in_ready_s : in_ready_u), 0);
        lat = 0;
        while (!(sel ? out_valid_s : out_valid_u) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, longint'(lat), 8);
        check_res2(sel, tag, exp);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_bp_valid%0d", tag, c), longint'(sel ? out_valid_s : out_valid_u), 1);
            check($sformatf("%s_bp_rdy%0d", tag, c), longint'(sel ? in_ready_s : in_ready_u), 0);
            check_res2(sel, $sformatf("%s_bp%0d", tag, c), exp);
        end
        if (sel) out_ready_s = 1'b1; else out_ready_u = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s = 1'b0;
        out_ready_u = 1'b0;
        check({tag, "_drain_valid"}, longint'(sel ? out_valid_s : out_valid_u), 0);
        check({tag, "_drain_rdy"}, longint'(sel ? in_ready_s : in_ready_u), 1);
    endtask

    initial begin
        int     lat;
        longint exp3 [9];

        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        a_2         = '0;
        b_2         = '0;
        a_3         = '0;
        b_3         = '0;
        in_valid_u  = 1'b0;
        in_valid_s  = 1'b0;
        in_valid_3  = 1'b0;
        out_ready_u = 1'b0;
        out_ready_s = 1'b0;
        out_ready_3 = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rdy_u", longint'(in_ready_u), 1);
        check("rst_valid_u", longint'(out_valid_u), 0);
        check("rst_res_u_zero", longint'(res_u == '0), 1);
        check("rst_valid_3", longint'(out_valid_3), 0);
        check("rst_res_3_zero", longint'(res_3 == '0), 1);
        rst_n = 1'b1;

        // Identity, unsigned max, then backpressure followed by a back-to-back job.
        run2(1'b0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd0, 8'd0, 8'd1},
             '{1, 2, 3, 4}, "ident", 0);
        run2(1'b0, {4{8'd255}}, {4{8'd255}},
             '{130050, 130050, 130050, 130050}, "umax", 0);
        run2(1'b0, {8'd5, 8'd6, 8'd7, 8'd8}, {8'd1, 8'd2, 8'd3, 8'd4},
             '{23, 34, 31, 46}, "bp", 5);
        run2(1'b0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
             '{19, 22, 43, 50}, "b2b", 0);

        // Signed extremes and mixed signs.
        run2(1'b1, {4{8'h80}}, {4{8'h80}},
             '{32768, 32768, 32768, 32768}, "smin", 0);
        run2(1'b1, {8'd1, 8'hFF, 8'd2, 8'd3}, {8'hFC, 8'd5, 8'd6, 8'hF9},
             '{-10, 12, 10, -11}, "smix", 0);

        // Reset during the fourth CALC cycle aborts the job.
        @(negedge clk);
        a_2 = {8'd9, 8'd9, 8'd9, 8'd9};
        b_2 = {8'd9, 8'd9, 8'd9, 8'd9};
        in_valid_u = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_u = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", longint'(out_valid_u), 0);
        check("abort_rdy", longint'(in_ready_u), 1);
        check("abort_res_zero", longint'(res_u == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_result", longint'(out_valid_u), 0);
        run2(1'b0, {8'd2, 8'd0, 8'd0, 8'd2}, {8'd1, 8'd2, 8'd3, 8'd4},
             '{2, 4, 6, 8}, "post_rst", 0);

        // N=3, DW=4: A = B = 1..9, ACC_W = 10.
        exp3 = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        @(negedge clk);
        a_3 = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        b_3 = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        in_valid_3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_3 = 1'b0;
        lat = 0;
        while (!out_valid_3 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("n3_latency", longint'(lat), 27);
        for (int e = 0; e < 9; e++) begin
            check($sformatf("n3_res%0d", e), longint'(res_3[(8-e)*10 +: 10]), exp3[e]);
        end
        out_ready_3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_3 = 1'b0;
        check("n3_drain_valid", longint'(out_valid_3), 0);
        check("n3_drain_rdy", longint'(in_ready_3), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
- Parametrised NxN integer matrix multiplier. Computes Res = A x B from flattened operand buses using one time-shared multiply-accumulate unit.
- Successor to the fixed 2x2 combinational multiplier. Adds generic N and DW, signed/unsigned mode, overflow-free accumulator width, and valid/ready handshakes on input and output.
- Sits between the operand-load logic and the result consumer in the matrix datapath.

Parameters:
- N, 2, matrix dimension (N >= 2)
- DW, 8, element width of A and B
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned
- ACC_W, 2*DW+clog2(N), result element width; must not be overridden smaller

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  A and B are valid
- in_ready  out  1  block can accept operands
- A  in  N*N*DW  matrix A, row-major, A[0][0] in MSBs, A[N-1][N-1] in LSBs
- B  in  N*N*DW  matrix B, same packing as A
- out_valid  out  1  Res holds a complete product
- out_ready  in  1  consumer accepts Res
- Res  out  N*N*ACC_W  product matrix, row-major, Res[0][0] in MSBs

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, Res=0, all counters and accumulator 0.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: register A and B internally, set i=j=k=0, acc=0, go to CALC.
  - Input buses are not sampled again until the next IDLE.
- CALC:
  - in_ready=0. One MAC per cycle: sum = acc + A[i][k]*B[k][j], with operands extended to ACC_W (sign-extended if SIGNED, else zero-extended).
  - If k<N-1: acc <= sum, k <= k+1.
  - If k==N-1: Res[i][j] <= sum, acc <= 0, k <= 0, then advance j; on j wrap, advance i.
  - The cycle with i=j=k=N-1 writes the last element and moves to DONE.
- Latency: out_valid rises exactly N^3 clock edges after the accepting edge (N=2: 8 cycles).
- DONE:
  - out_valid=1, in_ready=0. Res is stable while out_valid=1.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE. The next operand set can be accepted on the following edge; no overlap of jobs.
- Res is valid only while out_valid=1. During CALC it is partially overwritten element by element.
- Arithmetic: ACC_W makes overflow impossible. Worst cases are N*(2^DW-1)^2 unsigned and N*2^(2DW-2) signed. No saturation and no wrap logic.
- in_valid during CALC or DONE is ignored; the upstream must hold operands until in_ready.
- out_ready while not out_valid has no effect.
- Reset asserted mid-CALC or in DONE aborts the job immediately: out_valid=0, and no result is produced for the aborted operands.
- Counters i, j, k are clog2(N) bits wide and wrap only through the explicit compare to N-1, never through natural overflow.

Decomposition:
- Shared package mat_pkg holds:
  - clog2 constant function
  - state encoding (IDLE=0, CALC=1, DONE=2)
  - default ACC_W expression
- One sub-module, mat_mac: combinational DW x DW multiply plus ACC_W add, with SIGNED parameter. Allows a pipelined MAC later without touching the FSM.
- Operand indexing and Res packing stay in mat_mult_seq.

Test Plan:
- Identity case, N=2, SIGNED=0: A={1,2,3,4}, B={1,0,0,1}. Expect Res={1,2,3,4}, out_valid exactly 8 cycles after acceptance.
- Unsigned max, N=2: all A and B elements 255. Expect every Res element 130050 (ACC_W=17), no wrap.
- Signed extremes, N=2, SIGNED=1: all elements -128. Expect every Res element +32768. Then A={1,-1,2,3}, B={-4,5,6,-7}. Expect Res={-10,12,10,-11}.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Expect Res and out_valid stable and in_ready=0. Pulse out_ready: expect out_valid=0 and in_ready=1 next cycle. Back-to-back second job produces the correct result.
- Mid-operation reset: assert reset at CALC cycle 4. Expect out_valid=0 and in_ready=1 immediately, and Res=0. A new job after release completes correctly in 8 cycles.
- N=3, DW=4 unsigned: A=B={1..9} row-major. Expect Res={30,36,42,66,81,96,102,126,150}, latency 27 cycles, ACC_W=10.
